// File: rtl/pulse_code_pkg.sv
// Shared definitions for the pulse-time code: decoder FSM states, pulse polarity,
// and the thermometer-shift mapping shared with the encoder side.
package pulse_code_pkg;

    localparam int CODE_WIDTH = 8;

    // Encoder pulse is active-low.
    localparam logic PULSE_ACTIVE = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } decoder_state_t;

    // All-ones shifted right by k: the value carried by a pulse at offset k.
    function automatic logic [CODE_WIDTH-1:0] thermo_shift(input int unsigned k);
        logic [CODE_WIDTH-1:0] ones;
        ones = '1;
        return (k >= CODE_WIDTH) ? '0 : (ones >> k);
    endfunction

endpackage

// File: rtl/decoder_pulse_t_if.sv
// Result channel of the pulse decoder.
// valid/ready: a transfer happens on any clock edge where valid && ready. Once valid
// is raised, value and timeout stay stable until that transfer; valid is never
// withdrawn without a transfer (except by reset). ready may change freely.
interface decoder_pulse_t_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] value;
    logic             timeout;
    logic             valid;
    logic             ready;

    modport master (output value, output timeout, output valid, input ready);
    modport slave  (input value, input timeout, input valid, output ready);
endinterface

// File: rtl/decoder_pulse_t.sv
// Pulse-time decoder: measures how many cycles after a window start the active-low
// encoder pulse arrives and turns that offset k into all-ones >> k. A window with no
// pulse yields value 0 flagged as timeout. Results sit in a one-entry output register
// that is independent of the FSM, so a new window can run while a result is pending.
module decoder_pulse_t
    import pulse_code_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = WIDTH + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      incoming_line,
    decoder_pulse_t_if.master         outgoing,
    output logic                      dropped,
    output decoder_state_t            fsm_state
);

    localparam int OFF_W = $clog2(TIMEOUT + 1);
    localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(TIMEOUT);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    decoder_state_t   state_q, state_d;
    logic [OFF_W-1:0] offset_q, offset_d;

    // Result produced at the current edge (combinational, consumed by the output register).
    logic             res_valid;
    logic [WIDTH-1:0] res_value;
    logic             res_timeout;

    assign fsm_state = state_q;

    // FSM state and offset counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
        end
    end

    // Next state, offset and result. start has priority over everything, including a
    // pulse on the same edge. Timeout is checked before the line so that a window
    // that ran past the last legal offset always closes with the no-spike result.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        res_valid   = 1'b0;
        res_value   = '0;
        res_timeout = 1'b0;
        if (start) begin
            state_d  = ARMED;
            offset_d = '0;
        end else if (state_q == ARMED) begin
            if (offset_q == OFF_LAST) begin
                res_valid   = 1'b1;
                res_timeout = 1'b1;
                state_d     = IDLE;
            end else if (incoming_line == PULSE_ACTIVE) begin
                res_valid = 1'b1;
                res_value = ALL_ONES >> offset_q;
                state_d   = IDLE;
            end else begin
                offset_d = offset_q + 1'b1;
            end
        end
    end

    // Output register with valid/ready handshake and sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outgoing.value   <= '0;
            outgoing.timeout <= 1'b0;
            outgoing.valid   <= 1'b0;
            dropped          <= 1'b0;
        end else if (res_valid && (!outgoing.valid || outgoing.ready)) begin
            outgoing.value   <= res_value;
            outgoing.timeout <= res_timeout;
            outgoing.valid   <= 1'b1;
        end else begin
            if (outgoing.valid && outgoing.ready) begin
                outgoing.valid <= 1'b0;
            end
            if (res_valid) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule
